audio_fir_decim: RTL and testbench

Audio low-pass FIR filter with integer decimation, placed directly downstream of the FM demodulator. It pops demodulated samples from the demod output FIFO, filters them with a TAPS-tap fixed-point (Q10) FIR, and pushes one filtered sample to the audio FIFO for every DECIM input samples. The MAC is sequential, one tap per cycle, and is sized for the low audio-path sample rate.

---
 rtl/audio_fir_decim.sv | 98 +++++++++
 tb/tb_audio_fir_decim.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_fir_decim.sv
`default_nettype none
// ============================================================================
// audio_fir_decim : sequential Q10 FIR low-pass filter with integer decimation
// Revision 1.0 : initial release
// ============================================================================
module audio_fir_decim #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int DECIM      = 8,
  parameter logic [TAPS*DATA_WIDTH-1:0] COEFFS = {TAPS{DATA_WIDTH'(32)}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic                  x_empty,
  output logic                  x_rd_en,
  output logic [DATA_WIDTH-1:0] y_out,
  input  logic                  y_full,
  output logic                  y_wr_en
);

  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CNT_W = $clog2(DECIM + 1);
  localparam int FRAC  = 10;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                        state;
  logic [CNT_W-1:0]              count;
  logic [TAP_W-1:0]              tap;
  logic signed [DATA_WIDTH-1:0]  dline [TAPS];
  logic signed [DATA_WIDTH-1:0]  coef  [TAPS];
  logic signed [DATA_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH-1:0]  prod;
  logic signed [DATA_WIDTH-1:0]  term;

  generate
    for (genvar k = 0; k < TAPS; k++) begin : g_coef
      assign coef[k] = $signed(COEFFS[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  endgenerate

  // Product is kept at DATA_WIDTH bits, then floored per tap by the arithmetic shift.
  always_comb begin
    prod = coef[tap] * dline[tap];
    term = prod >>> FRAC;
  end

  assign x_rd_en = !rst && (state == READ)  && !x_empty;
  assign y_wr_en = !rst && (state == WRITE) && !y_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= READ;
      count <= '0;
      tap   <= '0;
      acc   <= '0;
      y_out <= '0;
      for (int k = 0; k < TAPS; k++) dline[k] <= '0;
    end else begin
      case (state)
        READ: begin
          if (!x_empty) begin
            for (int k = 1; k < TAPS; k++) dline[k] <= dline[k-1];
            dline[0] <= $signed(x_in);
            if (count == CNT_W'(DECIM - 1)) begin
              count <= '0;
              acc   <= '0;
              tap   <= '0;
              state <= MAC;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        MAC: begin
          acc <= acc + term;
          if (tap == TAP_W'(TAPS - 1)) begin
            y_out <= acc + term;
            state <= WRITE;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        WRITE: begin
          if (!y_full) state <= READ;
        end
        default: state <= READ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_fir_decim.sv
`default_nettype none
// ============================================================================
// tb_audio_fir_decim : directed bench for audio_fir_decim (three coefficient sets)
// Revision 1.0 : initial release
// ============================================================================
module tb_audio_fir_decim;

  localparam int DW = 32;
  localparam int NT = 32;
  localparam int ND = 8;

  function automatic logic [NT*DW-1:0] ramp_coefs();
    logic [NT*DW-1:0] r;
    r = '0;
    for (int k = 0; k < NT; k++) r[k*DW +: DW] = DW'(k + 1);
    return r;
  endfunction

  localparam logic [NT*DW-1:0] C_RAMP = ramp_coefs();
  localparam logic [NT*DW-1:0] C_ONES = {NT{32'd1}};
  localparam logic [NT*DW-1:0] C_DC   = {NT{32'd32}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          y_full = 1'b0;
  logic          empty_base = 1'b0;
  logic          burst_en = 1'b0;
  logic          burst_ph = 1'b0;
  wire           x_empty;
  logic [DW-1:0] x_in_a = '0;
  logic [DW-1:0] x_in_b = 32'hFFFF_FFFF;
  logic [DW-1:0] x_in_c = 32'd1000;
  wire  [DW-1:0] y_out_a, y_out_b, y_out_c;
  wire           x_rd_en_a, x_rd_en_b, x_rd_en_c;
  wire           y_wr_en_a, y_wr_en_b, y_wr_en_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int last_pop = 0;
  int viol = 0;

  assign x_empty = burst_en ? burst_ph : empty_base;

  always #5 clk = ~clk;

  audio_fir_decim #(.DATA_WIDTH(DW), .TAPS(NT), .DECIM(ND), .COEFFS(C_RAMP)) dut_a (
    .clk(clk), .rst(rst), .x_in(x_in_a), .x_empty(x_empty), .x_rd_en(x_rd_en_a),
    .y_out(y_out_a), .y_full(y_full), .y_wr_en(y_wr_en_a));
  audio_fir_decim #(.DATA_WIDTH(DW), .TAPS(NT), .DECIM(ND), .COEFFS(C_ONES)) dut_b (
    .clk(clk), .rst(rst), .x_in(x_in_b), .x_empty(x_empty), .x_rd_en(x_rd_en_b),
    .y_out(y_out_b), .y_full(y_full), .y_wr_en(y_wr_en_b));
  audio_fir_decim #(.DATA_WIDTH(DW), .TAPS(NT), .DECIM(ND), .COEFFS(C_DC)) dut_c (
    .clk(clk), .rst(rst), .x_in(x_in_c), .x_empty(x_empty), .x_rd_en(x_rd_en_c),
    .y_out(y_out_c), .y_full(y_full), .y_wr_en(y_wr_en_c));

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Toggling source for the bursty-input phase.
  initial forever begin
    @(posedge clk);
    #1 burst_ph = ~burst_ph;
  end

  // Per-cycle monitor: pop bookkeeping and handshake-rule violations.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (x_rd_en_a) begin
      pop_cnt++;
      last_pop = cyc;
    end
    if ((x_rd_en_a && x_empty) || (y_wr_en_a && y_full) || (x_rd_en_a && y_wr_en_a) ||
        (x_rd_en_b != x_rd_en_a) || (x_rd_en_c != x_rd_en_a) ||
        (y_wr_en_b != y_wr_en_a) || (y_wr_en_c != y_wr_en_a))
      viol++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Hold x_in_a at its current value until the first pop, then drive zeros.
  task automatic feed_impulse(output int fp);
    bit found = 0;
    fp = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk); #1;
      if (x_rd_en_a) begin
        found = 1;
        fp = cyc;
      end
    end
    check("impulse_pop", found, 1);
    @(posedge clk); #1 x_in_a = '0;
  endtask

  task automatic wait_write(input string tag, input int ea, input int eb, input int ec,
                            input bit chk_lat);
    bit found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk); #1;
      if (y_wr_en_a) found = 1;
    end
    check({tag, "_found"}, found, 1);
    check({tag, "_a"}, $signed(y_out_a), ea);
    check({tag, "_b"}, $signed(y_out_b), eb);
    check({tag, "_c"}, $signed(y_out_c), ec);
    if (chk_lat) check({tag, "_latency"}, cyc - last_pop, NT + 1);
  endtask

  int ea [6] = '{8, 16, 24, 32, 0, 0};
  int eb [6] = '{-8, -16, -24, -32, -32, -32};
  int ec [6] = '{248, 496, 744, 992, 992, 992};

  initial begin
    int  fp;
    int  base;
    bit  found;

    // Reset state, with data available so the pop gating is exercised.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_y_a", $signed(y_out_a), 0);
    check("rst_y_b", $signed(y_out_b), 0);
    check("rst_y_c", $signed(y_out_c), 0);
    check("rst_rd_en", x_rd_en_a, 0);
    check("rst_wr_en", y_wr_en_a, 0);

    // Gap-free run; first output meets a 5-cycle full audio FIFO.
    @(posedge clk); #1;
    x_in_a = 32'd1024;
    rst    = 1'b0;
    y_full = 1'b1;
    feed_impulse(fp);
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk); #1;
      if (y_out_a != '0) found = 1;
    end
    check("stall_enter", found, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_wr_en", y_wr_en_a, 0);
      check("stall_rd_en", x_rd_en_a, 0);
      check("stall_y_hold", $signed(y_out_a), 8);
      @(posedge clk); #1;
      if (i == 4) y_full = 1'b0;
      @(negedge clk); #1;
    end
    check("bp_write", y_wr_en_a, 1);
    check("bp_a", $signed(y_out_a), ea[0]);
    check("bp_b", $signed(y_out_b), eb[0]);
    check("bp_c", $signed(y_out_c), ec[0]);
    for (int i = 1; i < 6; i++)
      wait_write($sformatf("out%0d", i), ea[i], eb[i], ec[i], 1'b1);

    // Bursty input from a fresh reset.
    @(posedge clk); #1;
    rst      = 1'b1;
    burst_en = 1'b1;
    x_in_a   = 32'd1024;
    repeat (2) @(posedge clk);
    #1;
    base = pop_cnt;
    rst  = 1'b0;
    feed_impulse(fp);
    wait_write("burst0", ea[0], eb[0], ec[0], 1'b1);
    check("burst_span", last_pop - fp, 2 * ND - 2);
    check("burst_pops", pop_cnt - base, ND);

    // Abort the second frame at MAC cycle 10.
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk); #1;
      if (pop_cnt - base == 2 * ND) found = 1;
    end
    check("frame2_pops", found, 1);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    check("abort_y_a", $signed(y_out_a), 0);
    check("abort_y_b", $signed(y_out_b), 0);
    check("abort_y_c", $signed(y_out_c), 0);
    check("abort_wr_en", y_wr_en_a, 0);
    check("abort_rd_en", x_rd_en_a, 0);

    @(posedge clk); #1;
    x_in_a = 32'd1024;
    base   = pop_cnt;
    rst    = 1'b0;
    feed_impulse(fp);
    wait_write("post_rst", 8, -8, 248, 1'b1);
    check("post_rst_pops", pop_cnt - base, ND);

    check("handshake_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
